// File: rtl/riscv_pkg.sv
// Shared types for the 64-bit RISC-V pipeline.
// Fetch FSM states and the instruction FIFO entry.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] addr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] npc_of(
        input logic [XLEN-1:0] a
    );
        return a + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO between fetch and decode.
// Head is registered so decode sees clean flop outputs.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  fetch_entry_t            push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    head_valid,
    output logic [ILEN-1:0]         head_instr,
    output logic [XLEN-1:0]         head_npc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_nxt;
    logic            do_pop;
    logic [CW-1:0]   rem;
    logic            hv_n;
    logic [ILEN-1:0] hi_n;
    logic [XLEN-1:0] hn_n;

    assign do_pop = pop && head_valid;

    // Next head: oldest remaining entry, else the one arriving now.
    always_comb begin
        rd_nxt = rd_ptr + AW'(do_pop);
        rem    = count - CW'(do_pop);
        hv_n   = 1'b0;
        hi_n   = head_instr;
        hn_n   = head_npc;
        if (rem != '0) begin
            hv_n = 1'b1;
            hi_n = mem[rd_nxt].instr;
            hn_n = npc_of(mem[rd_nxt].addr);
        end else if (push) begin
            hv_n = 1'b1;
            hi_n = push_data.instr;
            hn_n = npc_of(push_data.addr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_instr <= '0;
            head_npc   <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_nxt;
            count      <= rem + CW'(push);
            head_valid <= hv_n;
            head_instr <= hi_n;
            head_npc   <= hn_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding memory port, FIFO to decode.
// Define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [ILEN-1:0] mem_rdata,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [ILEN-1:0] instr_reg,
    output logic [XLEN-1:0] IFID_npc,
    output logic            IFID_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic            drop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            gnt;
    logic            resp;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    logic            unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign gnt  = (state == REQ) && mem_gnt;
    assign resp = (state == WAIT) && mem_rvalid;
    assign push = resp && !drop && !redirect_valid;
    assign pop  = IFID_ready && !id_stall;

    assign push_entry = '{instr: mem_rdata, addr: req_addr};

    always_comb begin
        count_nxt = '0;
        if (!redirect_valid) begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // A redirect parks in IDLE so the new PC issues from a flushed FIFO.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && count < CW'(DEPTH)) state_nxt = REQ;
            end
            REQ: begin
                if (mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (!redirect_valid && count_nxt < CW'(DEPTH)) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state == REQ);
        mem_addr = req_addr;
    end

    // A stale request (drop set) does not advance the redirected PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
            else if (gnt && !drop) pc <= pc + 64'd4;
            if (state != REQ && state_nxt == REQ) req_addr <= pc;
            if (redirect_valid) begin
                drop <= (state == REQ) || (state == WAIT && !mem_rvalid);
            end else if (resp) begin
                drop <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (IFID_ready),
        .head_instr (instr_reg),
        .head_npc   (IFID_npc)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 64'd1;
            if (IFID_ready && id_stall) perf_stall <= perf_stall + 64'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 64-bit RISC-V pipeline. It sits directly upstream of the decode stage (`decodeMod`).
- Holds the PC and issues 32-bit instruction reads over a single-outstanding request/grant/response memory port.
- Buffers returned instructions in a small FIFO and presents them to decode as `instr_reg`/`IFID_npc`/`IFID_ready`.
- On a redirect from execute, flushes everything in flight and restarts fetching at the new PC.

## Interface
Reset is asynchronous and active-low.

Parameters:
- `RESET_PC`, 64'h0, first fetch address after reset.
- `DEPTH`, 2, instruction FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  read request valid.
- `mem_addr`  out  64  request address (word aligned).
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  response valid.
- `mem_rdata`  in  32  response instruction.
- `id_stall`  in  1  decode cannot accept this cycle.
- `redirect_valid`  in  1  branch/jump taken.
- `redirect_pc`  in  64  new fetch address; bits [1:0] ignored.
- `instr_reg`  out  32  head instruction.
- `IFID_npc`  out  64  head instruction PC + 4.
- `IFID_ready`  out  1  head valid.
- `perf_fetched`, `perf_stall`  out  64 each  only with `FETCH_PERF_EN`.

## Operation
- FSM states:
  - IDLE: FIFO lacks space.
  - REQ: `mem_req`=1, held stable until `mem_gnt`.
  - WAIT: one request outstanding.
- Issue condition: `count + outstanding < DEPTH`.
- IDLE→REQ when the issue condition holds.
- REQ→WAIT on `mem_gnt`, then `pc <= pc+4`.
- WAIT→REQ/IDLE on `mem_rvalid`, per the issue condition evaluated after the push.
- Response handling: pushes `{mem_rdata, addr}` into the FIFO unless `drop` is set; if `drop` is set the response is discarded and `drop` clears.
- Pop: the FIFO pops when `IFID_ready && !id_stall`. Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect (`redirect_valid`), each cycle:
  - `pc <= {redirect_pc[63:2],2'b00}`.
  - FIFO cleared; any same-cycle pop or push is discarded.
  - If a request is granted-but-unanswered, or is granted this cycle, set `drop`.
  - An ungranted request in REQ keeps its old address until granted (then dropped); fetch then restarts at the new PC.
  - Redirect has priority over every other event.
- Arithmetic: the PC wraps modulo 2^64; `IFID_npc` = entry address + 4, also wrapping.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `IFID_ready`=0, `instr_reg`=0, `IFID_npc`=0, `pc`=`RESET_PC`, FIFO empty, `drop`=0, state IDLE, perf counters 0.
- First `mem_req` rises on the first clock edge after `reset` deasserts.
- Grant in cycle T: `mem_rvalid` is legal from T+1 onward; a response in cycle R gives `IFID_ready`=1 in R+1.
- Peak throughput: one instruction per two cycles.
- Redirect in cycle T: `IFID_ready`=0 in T+1. The earliest new-PC instruction reaches decode in T+4, assuming zero-wait grant and next-cycle response.
- Reset asserted mid-transaction: all state is cleared immediately; the memory side must also reset.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetched` increments per non-dropped push.
  - `perf_stall` increments per cycle with `IFID_ready && id_stall`.
  - Both wrap and are cleared by reset or by nothing else.
- `FETCH_PERF_EN` undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`=64, `ILEN`=32.
  - `fetch_state_t` enum {IDLE, REQ, WAIT}.
  - `fetch_entry_t` struct {instr, addr}.
- Sub-module `fetch_fifo`: parameterised `DEPTH`, push/pop/flush, `count` output, registered head outputs.
- The FSM, PC and drop logic live in `fetch_stage`.

## Test plan
- Reset release, memory grants immediately and answers next cycle with 0x00000013: `mem_addr`=0, 4, 8…; decode sees `instr_reg`=0x00000013 with `IFID_npc`=4, 8, 12.
- `id_stall` held high for 10 cycles, `DEPTH`=2: exactly two entries fill, `mem_req` stays 0 while full; release pops 2 entries in 2 consecutive cycles.
- Redirect to 0x1003 while in WAIT: the in-flight response is dropped (never appears on `IFID_ready`); next `mem_addr`=0x1000, first `IFID_npc`=0x1004.
- Redirect in the same cycle as a pop and a push: FIFO empty next cycle, `IFID_ready`=0, `drop` not set.
- `mem_gnt` withheld 5 cycles: `mem_req`=1 and `mem_addr` constant throughout.
- `FETCH_PERF_EN` build: 8 fetched instructions, 3 stall cycles → `perf_fetched`=8, `perf_stall`=3.
